// File: rtl/hazard_ctrl.sv
// Interlock and flush generator for the 5-stage pipeline.
// Define HAZARD_STATS_EN to add saturating per-state cycle counters.
module hazard_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_use_hilo,
    input  logic [4:0]       ex_dst,
    input  logic             ex_memread,
    input  logic             md_start,
    input  logic             branch_taken,
    input  logic             icache_miss,
    input  logic             dcache_miss,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_stall,
    output logic             id_ex_flush,
    output logic             ex_mem_stall,
    output logic             mem_wb_flush,
    output logic             md_busy
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_freeze,
    output logic [CNT_W-1:0] stat_flush,
    output logic [CNT_W-1:0] stat_interlock,
    output logic [CNT_W-1:0] stat_fetch
`endif
);

    localparam logic [5:0] MD_LOAD = 6'(MD_LATENCY);

    logic [5:0] r_md_cnt;
    logic       r_flush_pend;
    logic       w_load_use;
    logic       w_md_hz;
    logic       w_freeze;
    logic       w_flush;
    logic       w_ilock;
    logic       w_fetch;

    assign w_load_use = ex_memread & (ex_dst != 5'd0) &
                        ((id_use_rs & (ex_dst == id_rs)) |
                         (id_use_rt & (ex_dst == id_rt)));
    assign w_md_hz = id_use_hilo & ((r_md_cnt != 6'd0) | md_start);

    // Mutually exclusive states; reset forces every control output low.
    assign w_freeze = reset & dcache_miss;
    assign w_flush  = reset & ~dcache_miss & (branch_taken | r_flush_pend);
    assign w_ilock  = reset & ~dcache_miss & ~w_flush & (w_load_use | w_md_hz);
    assign w_fetch  = reset & ~dcache_miss & ~w_flush &
                      ~(w_load_use | w_md_hz) & icache_miss;

    assign pc_stall     = w_freeze | w_ilock | w_fetch;
    assign if_id_stall  = w_freeze | w_ilock;
    assign if_id_flush  = w_flush | w_fetch;
    assign id_ex_stall  = w_freeze;
    assign id_ex_flush  = w_flush | w_ilock;
    assign ex_mem_stall = w_freeze;
    assign mem_wb_flush = w_freeze;
    assign md_busy      = (r_md_cnt != 6'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_md_cnt     <= 6'd0;
            r_flush_pend <= 1'b0;
        end else begin
            if (!dcache_miss) begin
                if (md_start)
                    r_md_cnt <= MD_LOAD;
                else if (r_md_cnt != 6'd0)
                    r_md_cnt <= r_md_cnt - 6'd1;
            end
            // A branch resolved under a freeze is replayed once MEM is ready.
            r_flush_pend <= dcache_miss ? (r_flush_pend | branch_taken) : 1'b0;
        end
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] r_stat_freeze;
    logic [CNT_W-1:0] r_stat_flush;
    logic [CNT_W-1:0] r_stat_interlock;
    logic [CNT_W-1:0] r_stat_fetch;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stat_freeze    <= '0;
            r_stat_flush     <= '0;
            r_stat_interlock <= '0;
            r_stat_fetch     <= '0;
        end else begin
            if (w_freeze && (r_stat_freeze != '1))
                r_stat_freeze <= r_stat_freeze + 1'b1;
            if (w_flush && (r_stat_flush != '1))
                r_stat_flush <= r_stat_flush + 1'b1;
            if (w_ilock && (r_stat_interlock != '1))
                r_stat_interlock <= r_stat_interlock + 1'b1;
            if (w_fetch && (r_stat_fetch != '1))
                r_stat_fetch <= r_stat_fetch + 1'b1;
        end
    end

    assign stat_freeze    = r_stat_freeze;
    assign stat_flush     = r_stat_flush;
    assign stat_interlock = r_stat_interlock;
    assign stat_fetch     = r_stat_fetch;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (MD_LATENCY=4).
// Output vector order: pc,ifid_st,ifid_fl,idex_st,idex_fl,exmem_st,memwb_fl,busy.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] id_rs, id_rt, ex_dst;
    logic       id_use_rs, id_use_rt, id_use_hilo;
    logic       ex_memread, md_start, branch_taken;
    logic       icache_miss, dcache_miss;
    logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall;
    logic       id_ex_flush, ex_mem_stall, mem_wb_flush, md_busy;
`ifdef HAZARD_STATS_EN
    logic [31:0] stat_freeze, stat_flush, stat_interlock, stat_fetch;
`endif

    int checks   = 0;
    int failures = 0;

    localparam logic [7:0] RUN    = 8'b0000_0000;
    localparam logic [7:0] ILOCK  = 8'b1100_1000;
    localparam logic [7:0] FREEZE = 8'b1101_0110;
    localparam logic [7:0] FLUSH  = 8'b0010_1000;
    localparam logic [7:0] FETCH  = 8'b1010_0000;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_LATENCY(4), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_use_hilo(id_use_hilo),
        .ex_dst(ex_dst), .ex_memread(ex_memread),
        .md_start(md_start), .branch_taken(branch_taken),
        .icache_miss(icache_miss), .dcache_miss(dcache_miss),
        .pc_stall(pc_stall), .if_id_stall(if_id_stall),
        .if_id_flush(if_id_flush), .id_ex_stall(id_ex_stall),
        .id_ex_flush(id_ex_flush), .ex_mem_stall(ex_mem_stall),
        .mem_wb_flush(mem_wb_flush), .md_busy(md_busy)
`ifdef HAZARD_STATS_EN
        ,
        .stat_freeze(stat_freeze), .stat_flush(stat_flush),
        .stat_interlock(stat_interlock), .stat_fetch(stat_fetch)
`endif
    );

    wire [7:0] outs = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                       id_ex_flush, ex_mem_stall, mem_wb_flush, md_busy};

    task automatic check(input string tag, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic clear_in();
        id_rs = 0; id_rt = 0; ex_dst = 0;
        id_use_rs = 0; id_use_rt = 0; id_use_hilo = 0;
        ex_memread = 0; md_start = 0; branch_taken = 0;
        icache_miss = 0; dcache_miss = 0;
    endtask

    // Check outputs mid-cycle, then move past the next rising edge.
    task automatic vec(input string tag, input logic [7:0] exp);
        @(negedge clk);
        check(tag, {24'd0, outs}, {24'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        clear_in();
        reset = 1'b0;
        #12;
        check("reset_outs", {24'd0, outs}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // load-use on rs
        ex_memread = 1; ex_dst = 5'd8; id_rs = 5'd8; id_use_rs = 1;
        vec("lu_rs", ILOCK);
        clear_in();
        vec("lu_rs_after", RUN);
        // load-use on rt
        ex_memread = 1; ex_dst = 5'd9; id_rt = 5'd9; id_use_rt = 1;
        vec("lu_rt", ILOCK);
        id_use_rt = 0;
        vec("lu_rt_unused", RUN);
        // register 0 and non-load
        clear_in();
        ex_memread = 1; ex_dst = 5'd0; id_rs = 5'd0; id_use_rs = 1;
        vec("lu_r0", RUN);
        ex_memread = 0; ex_dst = 5'd8; id_rs = 5'd8;
        vec("no_load", RUN);
        clear_in();

        icache_miss = 1;
        vec("fetch_wait", FETCH);
        clear_in();

        // mul/div: hilo read behind md_start
        md_start = 1; id_use_hilo = 1;
        vec("md_c0", ILOCK);
        md_start = 0;
        vec("md_c1", ILOCK | 8'h01);
        vec("md_c2", ILOCK | 8'h01);
        vec("md_c3", ILOCK | 8'h01);
        vec("md_c4", ILOCK | 8'h01);
        vec("md_c5", RUN);
        clear_in();

        // branch during freeze
        dcache_miss = 1; branch_taken = 1;
        vec("frz_c0", FREEZE);
        branch_taken = 0;
        vec("frz_c1", FREEZE);
        vec("frz_c2", FREEZE);
        dcache_miss = 0;
        vec("frz_flush", FLUSH);
        vec("frz_after", RUN);

        // flush outranks interlock and fetch-wait
        branch_taken = 1; icache_miss = 1;
        ex_memread = 1; ex_dst = 5'd8; id_rs = 5'd8; id_use_rs = 1;
        vec("prio", FLUSH);
        clear_in();
        vec("prio_after", RUN);

        // async reset with md_cnt=3
        md_start = 1;
        vec("mdr_start", RUN);
        md_start = 0;
        vec("mdr_busy", 8'h01);
        dcache_miss = 1; id_use_hilo = 1;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst", {24'd0, outs}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        clear_in();
        @(posedge clk);
        #1;
        id_use_hilo = 1;
        vec("hilo_post_rst", RUN);
        clear_in();

`ifdef HAZARD_STATS_EN
        dcache_miss = 1;
        vec("st_frz0", FREEZE);
        vec("st_frz1", FREEZE);
        dcache_miss = 0; branch_taken = 1;
        vec("st_flush", FLUSH);
        branch_taken = 0; icache_miss = 1;
        vec("st_fetch0", FETCH);
        vec("st_fetch1", FETCH);
        vec("st_fetch2", FETCH);
        clear_in();
        @(negedge clk);
        check("stat_freeze", stat_freeze, 32'd2);
        check("stat_flush", stat_flush, 32'd1);
        check("stat_interlock", stat_interlock, 32'd0);
        check("stat_fetch", stat_fetch, 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
